// File: rtl/yarr_rx_pkg.sv
// Shared RX definitions: sync-header codes and block-sync FSM states.
package yarr_rx_pkg;

  localparam logic [1:0] C_DATA_HEADER = 2'b01;
  localparam logic [1:0] C_CMD_HEADER  = 2'b10;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } sync_state_t;

  function automatic logic is_sync_header(input logic [1:0] hdr);
    return (hdr == C_DATA_HEADER) || (hdr == C_CMD_HEADER);
  endfunction

endpackage

// File: rtl/block_sync_locker_if.sv
// Gearbox-side input bundle and block-sync status outputs of block_sync_locker.
interface block_sync_locker_if #(
  parameter int unsigned BUF_W   = 194,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned BLOCK_W = 66
);
  localparam int unsigned OFF_W = $clog2(BLOCK_W);

  logic [BUF_W-1:0] gbox_buffer;
  logic [CNT_W-1:0] gbox_cnt;
  logic             buffer_dv;
  logic             force_relock_i;
  logic [OFF_W-1:0] block_offset;
  logic             locked_o;
  logic [1:0]       header_o;
  logic             header_valid_o;
  logic             slip_o;
  logic             cnt_err_o;

  modport master (
    output gbox_buffer, gbox_cnt, buffer_dv, force_relock_i,
    input  block_offset, locked_o, header_o, header_valid_o, slip_o, cnt_err_o
  );

  modport slave (
    input  gbox_buffer, gbox_cnt, buffer_dv, force_relock_i,
    output block_offset, locked_o, header_o, header_valid_o, slip_o, cnt_err_o
  );

endinterface

// File: rtl/block_sync_window.sv
// Captures a BLOCK_W+1 window out of the gearbox buffer and muxes out the
// two header bits at the current candidate offset.
module block_sync_window
  import yarr_rx_pkg::*;
#(
  parameter int unsigned BUF_W   = 194,
  parameter int unsigned BLOCK_W = 66,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned OFF_W   = $clog2(BLOCK_W)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [BUF_W-1:0] gbox_buffer,
  input  logic [CNT_W-1:0] gbox_cnt,
  input  logic             buffer_dv,
  input  logic [OFF_W-1:0] offset,
  output logic             win_vld,
  output logic [1:0]       hdr,
  output logic             cnt_err
);

  localparam int unsigned CNT_MAX = BUF_W - BLOCK_W - 1;

  logic [BLOCK_W:0] win;
  logic [BUF_W-1:0] aligned;
  logic [BLOCK_W:0] shifted;
  logic             in_range;

  // Shifts stand in for the variable part-selects so out-of-range indices never form.
  always_comb begin
    in_range = (32'(gbox_cnt) <= CNT_MAX);
    aligned  = gbox_buffer << gbox_cnt;
    shifted  = win << offset;
    hdr      = shifted[BLOCK_W -: 2];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win     <= '0;
      win_vld <= 1'b0;
      cnt_err <= 1'b0;
    end else begin
      win_vld <= buffer_dv && in_range;
      cnt_err <= buffer_dv && !in_range;
      if (buffer_dv && in_range) begin
        win <= aligned[BUF_W-1 -: BLOCK_W+1];
      end
    end
  end

endmodule

// File: rtl/block_sync_locker.sv
// 64b/66b block-sync engine: hunts the header offset, declares lock after
// LOCK_CNT good headers and drops it on UNLOCK_BAD bad headers within WIN.
module block_sync_locker
  import yarr_rx_pkg::*;
#(
  parameter int unsigned BUF_W      = 194,
  parameter int unsigned BLOCK_W    = 66,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned WIN        = 64,
  parameter int unsigned UNLOCK_BAD = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  block_sync_locker_if.slave  bus
);

  localparam int unsigned OFF_W  = $clog2(BLOCK_W);
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W  = $clog2(WIN + 1);

  localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(BLOCK_W - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]  HDR_LAST  = WIN_W'(WIN - 1);
  localparam logic [WIN_W-1:0]  BAD_LIMIT = WIN_W'(UNLOCK_BAD);

  sync_state_t       state_q, state_d;
  logic [OFF_W-1:0]  offset_q, offset_d, offset_inc;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [WIN_W-1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [WIN_W-1:0]  bad_cnt_q, bad_cnt_d, bad_sum;
  logic [1:0]        header_q, header_d;
  logic              hv_q, slip_q, slip_d;
  logic              win_vld, cnt_err, good;
  logic [1:0]        hdr;

  block_sync_window #(
    .BUF_W   (BUF_W),
    .BLOCK_W (BLOCK_W),
    .CNT_W   (CNT_W),
    .OFF_W   (OFF_W)
  ) u_window (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .gbox_buffer (bus.gbox_buffer),
    .gbox_cnt    (bus.gbox_cnt),
    .buffer_dv   (bus.buffer_dv),
    .offset      (offset_q),
    .win_vld     (win_vld),
    .hdr         (hdr),
    .cnt_err     (cnt_err)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SEARCH;
      offset_q   <= '0;
      good_cnt_q <= '0;
      hdr_cnt_q  <= '0;
      bad_cnt_q  <= '0;
      header_q   <= '0;
      hv_q       <= 1'b0;
      slip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      good_cnt_q <= good_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      header_q   <= header_d;
      hv_q       <= win_vld;
      slip_q     <= slip_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    good_cnt_d = good_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    header_d   = win_vld ? hdr : header_q;
    slip_d     = 1'b0;
    good       = is_sync_header(hdr);
    offset_inc = (offset_q == OFF_LAST) ? '0 : offset_q + OFF_W'(1);
    bad_sum    = bad_cnt_q + WIN_W'(!good);

    // The header strobe above still fires when a relock discards the evaluation.
    if (bus.force_relock_i) begin
      state_d    = SEARCH;
      offset_d   = '0;
      good_cnt_d = '0;
      hdr_cnt_d  = '0;
      bad_cnt_d  = '0;
    end else if (win_vld) begin
      case (state_q)
        SEARCH: begin
          if (good) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else begin
            good_cnt_d = '0;
            offset_d   = offset_inc;
            slip_d     = 1'b1;
          end
        end
        LOCKED: begin
          // Unlock check counts the current header before the window rollover.
          if (bad_sum == BAD_LIMIT) begin
            state_d   = SEARCH;
            offset_d  = offset_inc;
            slip_d    = 1'b1;
            hdr_cnt_d = '0;
            bad_cnt_d = '0;
          end else if (hdr_cnt_q == HDR_LAST) begin
            hdr_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + WIN_W'(1);
            bad_cnt_d = bad_sum;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign bus.block_offset   = offset_q;
  assign bus.locked_o       = (state_q == LOCKED);
  assign bus.header_o       = header_q;
  assign bus.header_valid_o = hv_q;
  assign bus.slip_o         = slip_q;
  assign bus.cnt_err_o      = cnt_err;

endmodule
